exec_control: RTL and testbench

Execution controller that sits directly upstream of the gated-clock/cycle-counter stage. It drives that stage's `enable` input and reads back its cycle count.
- Accepts one-byte commands from the debug unit: run, single-step, soft reset.
- Drives enable for exactly the requested number of cycles.
- Returns a completion report (final cycle count plus status) over a valid/ready handshake.

---
 rtl/exec_control_if.sv | 30 +++
 rtl/exec_control.sv | 153 +++++++++++++++
 tb/tb_exec_control.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/exec_control_if.sv
// Command/report bus between the debug unit, exec_control and the counter stage.
// The slave side belongs to exec_control; the master side belongs to whoever drives it.
interface exec_control_if #(
  parameter int unsigned NBITS = 32
);
  logic             i_cmd_valid;
  logic [7:0]       i_cmd;
  logic             o_cmd_ready;
  logic             i_halt;
  logic [NBITS-1:0] i_clock_count;
  logic             o_enable;
  logic             o_soft_reset;
  logic             o_done_valid;
  logic [NBITS-1:0] o_done_count;
  logic [1:0]       o_done_status;
  logic             i_done_ready;
  logic             o_busy;

  modport slave (
    input  i_cmd_valid, i_cmd, i_halt, i_clock_count, i_done_ready,
    output o_cmd_ready, o_enable, o_soft_reset, o_done_valid, o_done_count, o_done_status,
           o_busy
  );

  modport master (
    output i_cmd_valid, i_cmd, i_halt, i_clock_count, i_done_ready,
    input  o_cmd_ready, o_enable, o_soft_reset, o_done_valid, o_done_count, o_done_status,
           o_busy
  );
endinterface

// File: rtl/exec_control.sv
// Execution controller: turns run/step/soft-reset commands into a bounded enable window
// for the gated-clock counter stage and reports the resulting cycle count.
module exec_control #(
  parameter int unsigned NBITS      = 32,
  parameter int unsigned MAX_CYCLES = 1024,
  parameter logic [7:0]  CMD_RUN    = 8'h52,
  parameter logic [7:0]  CMD_STEP   = 8'h53,
  parameter logic [7:0]  CMD_RST    = 8'h58
) (
  input logic           clock,
  input logic           reset,
  exec_control_if.slave bus
);

  localparam int unsigned CntW = $clog2(MAX_CYCLES + 1);

  localparam logic [1:0] StatusOk      = 2'b00;
  localparam logic [1:0] StatusHalt    = 2'b01;
  localparam logic [1:0] StatusTimeout = 2'b10;
  localparam logic [1:0] StatusBad     = 2'b11;

  typedef enum logic [2:0] {StIdle, StRun, StStep, StSettle, StReport} state_e;

  state_e           state_q, state_d;
  logic             enable_q, enable_d;
  logic             soft_reset_q, soft_reset_d;
  logic             done_valid_q, done_valid_d;
  logic [NBITS-1:0] done_count_q, done_count_d;
  logic [1:0]       status_q, status_d;
  logic             halted_q, halted_d;
  logic [CntW-1:0]  run_cnt_q, run_cnt_d;

  logic cmd_accept;
  logic halt_seen;

  assign cmd_accept = bus.i_cmd_valid && (state_q == StIdle);
  // Halt only means something while the processor is actually being clocked.
  assign halt_seen  = bus.i_halt && enable_q;

  always_comb begin
    state_d      = state_q;
    enable_d     = enable_q;
    soft_reset_d = 1'b0;
    done_valid_d = done_valid_q;
    done_count_d = done_count_q;
    status_d     = status_q;
    halted_d     = halted_q;
    run_cnt_d    = run_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_accept) begin
          if (bus.i_cmd == CMD_RUN || bus.i_cmd == CMD_STEP) begin
            if (halted_q) begin
              status_d = StatusBad;
              state_d  = StSettle;
            end else if (bus.i_cmd == CMD_RUN) begin
              enable_d  = 1'b1;
              run_cnt_d = '0;
              state_d   = StRun;
            end else begin
              enable_d = 1'b1;
              state_d  = StStep;
            end
          end else if (bus.i_cmd == CMD_RST) begin
            soft_reset_d = 1'b1;
            halted_d     = 1'b0;
            status_d     = StatusOk;
            state_d      = StSettle;
          end else begin
            status_d = StatusBad;
            state_d  = StSettle;
          end
        end
      end

      StRun: begin
        run_cnt_d = run_cnt_q + 1'b1;
        if (halt_seen) begin
          enable_d = 1'b0;
          halted_d = 1'b1;
          status_d = StatusHalt;
          state_d  = StSettle;
        end else if (run_cnt_q == CntW'(MAX_CYCLES - 1)) begin
          // This edge closes the MAX_CYCLES-th enable cycle.
          enable_d = 1'b0;
          status_d = StatusTimeout;
          state_d  = StSettle;
        end
      end

      StStep: begin
        enable_d = 1'b0;
        state_d  = StSettle;
        if (halt_seen) begin
          halted_d = 1'b1;
          status_d = StatusHalt;
        end else begin
          status_d = StatusOk;
        end
      end

      StSettle: begin
        done_count_d = bus.i_clock_count;
        done_valid_d = 1'b1;
        state_d      = StReport;
      end

      StReport: begin
        if (bus.i_done_ready) begin
          done_valid_d = 1'b0;
          state_d      = StIdle;
        end
      end

      default: begin
        enable_d = 1'b0;
        state_d  = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      enable_q     <= 1'b0;
      soft_reset_q <= 1'b0;
      done_valid_q <= 1'b0;
      done_count_q <= '0;
      status_q     <= StatusOk;
      halted_q     <= 1'b0;
      run_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      enable_q     <= enable_d;
      soft_reset_q <= soft_reset_d;
      done_valid_q <= done_valid_d;
      done_count_q <= done_count_d;
      status_q     <= status_d;
      halted_q     <= halted_d;
      run_cnt_q    <= run_cnt_d;
    end
  end

  assign bus.o_cmd_ready   = (state_q == StIdle);
  assign bus.o_busy        = (state_q != StIdle);
  assign bus.o_enable      = enable_q;
  assign bus.o_soft_reset  = soft_reset_q;
  assign bus.o_done_valid  = done_valid_q;
  assign bus.o_done_count  = done_count_q;
  assign bus.o_done_status = status_q;

endmodule

// File: tb/tb_exec_control.sv
// Directed bench for exec_control with a small cycle-counter model behind o_enable.
module tb_exec_control;

  localparam int unsigned NBITS = 32;
  localparam int unsigned MAXC  = 16;

  logic clock;
  logic reset;
  logic cnt_clr;
  logic [NBITS-1:0] cnt;

  int checks;
  int failures;

  exec_control_if #(.NBITS(NBITS)) bus ();

  exec_control #(
    .NBITS      (NBITS),
    .MAX_CYCLES (MAXC),
    .CMD_RUN    (8'h52),
    .CMD_STEP   (8'h53),
    .CMD_RST    (8'h58)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Counter stage model: counts clock cycles during which enable is high.
  always @(posedge clock) begin
    if (cnt_clr) cnt <= '0;
    else if (bus.o_enable) cnt <= cnt + 1;
  end
  assign bus.i_clock_count = cnt;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_count();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
  endtask

  task automatic issue(input logic [7:0] c);
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd       = c;
    tick();
    bus.i_cmd_valid = 1'b0;
  endtask

  // Observes cycles after acceptance until the report shows up; latency counts the accept cycle.
  task automatic wait_report(input int halt_at, output int en_cyc, output int lat,
                             output int srst);
    int cyc;
    cyc    = 0;
    en_cyc = 0;
    srst   = 0;
    while (bus.o_done_valid !== 1'b1 && cyc < 64) begin
      cyc++;
      if (bus.o_enable) en_cyc++;
      if (bus.o_soft_reset) srst++;
      bus.i_halt = bus.o_enable && (halt_at != 0) && (en_cyc == halt_at);
      tick();
    end
    bus.i_halt = 1'b0;
    lat = cyc + 1;
    check_eq("report_arrived", {31'b0, bus.o_done_valid}, 32'd1);
  endtask

  task automatic consume();
    bus.i_done_ready = 1'b1;
    tick();
    bus.i_done_ready = 1'b0;
    check_eq("consume_valid_low", {31'b0, bus.o_done_valid}, 32'd0);
    check_eq("consume_cmd_ready", {31'b0, bus.o_cmd_ready}, 32'd1);
  endtask

  task automatic run_case(input string tag, input logic [7:0] c, input int halt_at,
                          input int exp_en, input int exp_lat, input int exp_srst,
                          input logic [31:0] exp_count, input logic [1:0] exp_status);
    int en_cyc, lat, srst;
    clear_count();
    issue(c);
    wait_report(halt_at, en_cyc, lat, srst);
    check_eq({tag, "_enable_cycles"}, en_cyc, exp_en);
    check_eq({tag, "_latency"}, lat, exp_lat);
    check_eq({tag, "_soft_reset"}, srst, exp_srst);
    check_eq({tag, "_count"}, bus.o_done_count, exp_count);
    check_eq({tag, "_status"}, {30'b0, bus.o_done_status}, {30'b0, exp_status});
    consume();
  endtask

  initial begin
    int en_cyc, lat, srst;
    checks           = 0;
    failures         = 0;
    reset            = 1'b1;
    cnt_clr          = 1'b1;
    bus.i_cmd_valid  = 1'b0;
    bus.i_cmd        = 8'h00;
    bus.i_halt       = 1'b0;
    bus.i_done_ready = 1'b0;
    repeat (2) tick();
    check_eq("rst_enable", {31'b0, bus.o_enable}, 32'd0);
    check_eq("rst_soft_reset", {31'b0, bus.o_soft_reset}, 32'd0);
    check_eq("rst_done_valid", {31'b0, bus.o_done_valid}, 32'd0);
    check_eq("rst_done_count", bus.o_done_count, 32'd0);
    check_eq("rst_done_status", {30'b0, bus.o_done_status}, 32'd0);
    check_eq("rst_cmd_ready", {31'b0, bus.o_cmd_ready}, 32'd1);
    check_eq("rst_busy", {31'b0, bus.o_busy}, 32'd0);
    reset   = 1'b0;
    cnt_clr = 1'b0;
    tick();

    //        tag           cmd    halt en lat srst count status
    run_case("step",        8'h53, 0,   1, 3,  0,   1,    2'b00);
    run_case("run_halt10",  8'h52, 10, 10, 12, 0,   10,   2'b01);
    run_case("step_halted", 8'h53, 0,   0, 2,  0,   0,    2'b11);
    run_case("soft_rst",    8'h58, 0,   0, 2,  1,   0,    2'b00);
    run_case("run_timeout", 8'h52, 0,  16, 18, 0,   16,   2'b10);
    run_case("run_halt16",  8'h52, 16, 16, 18, 0,   16,   2'b01);
    run_case("run_refused", 8'h52, 0,   0, 2,  0,   0,    2'b11);
    run_case("soft_rst2",   8'h58, 0,   0, 2,  1,   0,    2'b00);

    // Report back-pressure with a command already pending.
    clear_count();
    issue(8'h53);
    wait_report(0, en_cyc, lat, srst);
    check_eq("hold_step_status", {30'b0, bus.o_done_status}, 32'd0);
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd       = 8'h41;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("hold_valid", {31'b0, bus.o_done_valid}, 32'd1);
      check_eq("hold_count", bus.o_done_count, 32'd1);
      check_eq("hold_status", {30'b0, bus.o_done_status}, 32'd0);
      check_eq("hold_cmd_ready", {31'b0, bus.o_cmd_ready}, 32'd0);
    end
    bus.i_done_ready = 1'b1;
    tick();
    bus.i_done_ready = 1'b0;
    check_eq("hs_valid_low", {31'b0, bus.o_done_valid}, 32'd0);
    check_eq("hs_cmd_ready", {31'b0, bus.o_cmd_ready}, 32'd1);
    tick();
    bus.i_cmd_valid = 1'b0;
    check_eq("pending_accepted_busy", {31'b0, bus.o_busy}, 32'd1);
    wait_report(0, en_cyc, lat, srst);
    check_eq("bad_cmd_enable_cycles", en_cyc, 32'd0);
    check_eq("bad_cmd_latency", lat, 32'd2);
    check_eq("bad_cmd_status", {30'b0, bus.o_done_status}, 32'd3);
    consume();

    // Reset in the middle of a RUN.
    clear_count();
    issue(8'h52);
    repeat (3) tick();
    check_eq("mid_run_enable", {31'b0, bus.o_enable}, 32'd1);
    reset = 1'b1;
    tick();
    check_eq("rst_run_enable", {31'b0, bus.o_enable}, 32'd0);
    check_eq("rst_run_valid", {31'b0, bus.o_done_valid}, 32'd0);
    reset = 1'b0;
    repeat (3) tick();
    check_eq("post_rst_cmd_ready", {31'b0, bus.o_cmd_ready}, 32'd1);
    check_eq("post_rst_valid", {31'b0, bus.o_done_valid}, 32'd0);
    check_eq("post_rst_enable", {31'b0, bus.o_enable}, 32'd0);
    check_eq("post_rst_count_4", cnt, 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
